uart_frame_decoder: RTL and testbench

//  Receive-side deframer between the UART receiver and player2_mux.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/uart_frame_decoder.sv | 136 +++++++++++++
 tb/tb_uart_frame_decoder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared display geometry plus the game-state frame format exchanged over the UART link.
// Used by both the rx-side decoder and the tx-side encoder.
package vga_pkg;

  localparam int HOR_PIXELS = 640;
  localparam int VER_PIXELS = 480;
  localparam int BALLSIZE   = 16;
  localparam int PAD_HEIGHT = 80;

  localparam logic [7:0] UART_SYNC_BYTE    = 8'hA5;
  localparam int         FRAME_PAYLOAD_LEN = 6;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CSUM
  } uart_frame_state_t;

  typedef struct packed {
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic [9:0]  y_pad;
  } game_frame_t;

  // Centred ball and paddle; shown until the first good frame arrives.
  localparam game_frame_t FRAME_RESET = '{
    x_ball: 11'((HOR_PIXELS - BALLSIZE) / 2),
    y_ball: 10'((VER_PIXELS - BALLSIZE) / 2),
    y_pad:  10'((VER_PIXELS - PAD_HEIGHT) / 2)
  };

  function automatic logic frame_in_range(input game_frame_t f);
    return (f.x_ball < 11'(HOR_PIXELS)) &&
           (f.y_ball < 10'(VER_PIXELS)) &&
           (f.y_pad <= 10'(VER_PIXELS - PAD_HEIGHT));
  endfunction

endpackage

// File: rtl/uart_frame_decoder.sv
// Rebuilds remote ball/paddle positions from the uart_rx byte stream for player2_mux.
// Keeps the last good frame on its outputs and reports link loss through link_up.
module uart_frame_decoder
  import vga_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = UART_SYNC_BYTE,
  parameter int         BYTE_TIMEOUT = 100_000,
  parameter int         LINK_TIMEOUT = 4_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [10:0] x_ball_uart,
  output logic [9:0]  y_ball_uart,
  output logic [9:0]  y_player2_uart,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        link_up
);

  localparam int         GAP_W    = $clog2(BYTE_TIMEOUT + 1);
  localparam int         LINK_W   = $clog2(LINK_TIMEOUT + 1);
  localparam int         PAY_W    = 8 * FRAME_PAYLOAD_LEN;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_PAYLOAD_LEN - 1);

  uart_frame_state_t state, state_next;

  logic [PAY_W-1:0]  payload;
  logic [7:0]        csum_acc;
  logic [2:0]        idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [LINK_W-1:0] link_cnt;
  game_frame_t       frame_q;
  game_frame_t       candidate;

  logic start, capture, frame_ok, frame_bad, timeout, padding_ok, check_ok;

  // Payload bytes are shifted in MSB first, so byte 0 ends up in the top 8 bits.
  assign candidate.x_ball = payload[42:32];
  assign candidate.y_ball = payload[25:16];
  assign candidate.y_pad  = payload[9:0];
  assign padding_ok = (payload[47:43] == '0) && (payload[31:26] == '0) && (payload[15:10] == '0);
  assign check_ok   = (rx_data == csum_acc) && padding_ok && frame_in_range(candidate);

  // A byte arriving on the cycle the gap would expire still counts.
  assign timeout = (state != HUNT) && !rx_valid && (gap_cnt == GAP_W'(BYTE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          start      = 1'b1;
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          capture = 1'b1;
          if (idx == LAST_IDX) state_next = CSUM;
        end else if (timeout) begin
          frame_bad  = 1'b1;
          state_next = HUNT;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          frame_ok   = check_ok;
          frame_bad  = !check_ok;
          state_next = HUNT;
        end else if (timeout) begin
          frame_bad  = 1'b1;
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      payload  <= '0;
      csum_acc <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
    end else begin
      if (start) begin
        idx      <= '0;
        csum_acc <= '0;
      end else if (capture) begin
        payload  <= {payload[PAY_W-9:0], rx_data};
        csum_acc <= csum_acc ^ rx_data;
        idx      <= idx + 3'd1;
      end
      if ((state == HUNT) || rx_valid) gap_cnt <= '0;
      else                             gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  // Outputs move only on a fully checked frame; the link counter saturates while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q     <= FRAME_RESET;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      link_cnt    <= '0;
      link_up     <= 1'b0;
    end else begin
      frame_valid <= frame_ok;
      frame_err   <= frame_bad;
      if (frame_ok) begin
        frame_q  <= candidate;
        link_cnt <= '0;
        link_up  <= 1'b1;
      end else if (link_cnt != LINK_W'(LINK_TIMEOUT)) begin
        link_cnt <= link_cnt + LINK_W'(1);
        if (link_cnt == LINK_W'(LINK_TIMEOUT - 1)) link_up <= 1'b0;
      end
    end
  end

  assign x_ball_uart    = frame_q.x_ball;
  assign y_ball_uart    = frame_q.y_ball;
  assign y_player2_uart = frame_q.y_pad;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: a byte-level reference model is compared against
// the DUT every cycle, and literal expectations pin key points of each scenario.
module tb_uart_frame_decoder;
  import vga_pkg::*;

  localparam int BT = 40;
  localparam int LT = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [10:0] x_ball_uart;
  logic [9:0]  y_ball_uart;
  logic [9:0]  y_player2_uart;
  logic        frame_valid;
  logic        frame_err;
  logic        link_up;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       model_ready = 1'b0;
  bit [7:0] q[$];
  bit       in_frame;
  int       idle_cnt;
  int       since_good;
  int       exp_x, exp_yb, exp_yp;
  bit       exp_fv, exp_fe, exp_link;

  uart_frame_decoder #(
    .SYNC_BYTE   (8'hA5),
    .BYTE_TIMEOUT(BT),
    .LINK_TIMEOUT(LT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .x_ball_uart   (x_ball_uart),
    .y_ball_uart   (y_ball_uart),
    .y_player2_uart(y_player2_uart),
    .frame_valid   (frame_valid),
    .frame_err     (frame_err),
    .link_up       (link_up)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) applyStimulus(f[63-8*i -: 8]);
    idle(1);
  endtask

  task automatic check_frame(input string tag, input int x, input int yb, input int yp);
    checkOutput({tag, "_x"}, int'(x_ball_uart), x);
    checkOutput({tag, "_yb"}, int'(y_ball_uart), yb);
    checkOutput({tag, "_yp"}, int'(y_player2_uart), yp);
  endtask

  // Byte-level model: collects a frame after SYNC and judges it by value, not by bit fields.
  initial forever begin
    bit good;
    int xf, ybf, ypf;
    bit [7:0] cs;
    @(posedge clk);
    good   = 1'b0;
    exp_fv = 1'b0;
    exp_fe = 1'b0;
    if (rst) begin
      q.delete();
      in_frame    = 1'b0;
      idle_cnt    = 0;
      since_good  = 0;
      exp_link    = 1'b0;
      exp_x       = (HOR_PIXELS - BALLSIZE) / 2;
      exp_yb      = (VER_PIXELS - BALLSIZE) / 2;
      exp_yp      = (VER_PIXELS - PAD_HEIGHT) / 2;
      model_ready = 1'b1;
    end else begin
      if (rx_valid) begin
        idle_cnt = 0;
        if (!in_frame) begin
          if (rx_data == 8'hA5) begin
            in_frame = 1'b1;
            q.delete();
          end
        end else begin
          q.push_back(rx_data);
          if (q.size() == 7) begin
            in_frame = 1'b0;
            xf  = q[0] * 256 + q[1];
            ybf = q[2] * 256 + q[3];
            ypf = q[4] * 256 + q[5];
            cs  = q[0] ^ q[1] ^ q[2] ^ q[3] ^ q[4] ^ q[5];
            if ((cs == q[6]) && (xf < HOR_PIXELS) && (ybf < VER_PIXELS) &&
                (ypf <= VER_PIXELS - PAD_HEIGHT)) begin
              good   = 1'b1;
              exp_x  = xf;
              exp_yb = ybf;
              exp_yp = ypf;
              exp_fv = 1'b1;
            end else begin
              exp_fe = 1'b1;
            end
          end
        end
      end else if (in_frame) begin
        idle_cnt++;
        if (idle_cnt == BT) begin
          exp_fe   = 1'b1;
          in_frame = 1'b0;
        end
      end
      if (good) begin
        exp_link   = 1'b1;
        since_good = 0;
      end else if (exp_link) begin
        since_good++;
        if (since_good == LT) exp_link = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_ready) begin
      checkOutput("cmp_x", int'(x_ball_uart), exp_x);
      checkOutput("cmp_yb", int'(y_ball_uart), exp_yb);
      checkOutput("cmp_yp", int'(y_player2_uart), exp_yp);
      checkOutput("cmp_frame_valid", int'(frame_valid), int'(exp_fv));
      checkOutput("cmp_frame_err", int'(frame_err), int'(exp_fe));
      checkOutput("cmp_link_up", int'(link_up), int'(exp_link));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_frame("reset", 312, 232, 200);
    checkOutput("reset_link_up", int'(link_up), 0);

    $display("[TB] good frame");
    send_frame(64'hA5_01_90_01_2C_00_FA_46);
    check_frame("good", 400, 300, 250);
    checkOutput("good_frame_valid", int'(frame_valid), 1);
    checkOutput("good_link_up", int'(link_up), 1);
    idle(1);
    checkOutput("good_valid_single", int'(frame_valid), 0);

    $display("[TB] bad checksum");
    send_frame(64'hA5_01_90_01_2C_00_FA_47);
    checkOutput("csum_frame_err", int'(frame_err), 1);
    check_frame("csum_hold", 400, 300, 250);

    $display("[TB] byte timeout");
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h90);
    waited = -1;
    for (int i = 1; i <= BT + 5; i++) begin
      idle(1);
      if (frame_err) begin
        waited = i;
        break;
      end
    end
    checkOutput("timeout_wait", waited, BT + 1);

    $display("[TB] byte on the last allowed cycle");
    applyStimulus(8'hA5);
    idle(BT - 1);
    applyStimulus(8'h02);
    applyStimulus(8'h7F);
    applyStimulus(8'h01);
    applyStimulus(8'hDF);
    applyStimulus(8'h01);
    applyStimulus(8'h90);
    applyStimulus(8'h32);
    idle(1);
    checkOutput("edge_frame_valid", int'(frame_valid), 1);
    check_frame("edge", 639, 479, 400);

    send_frame(64'hA5_02_7F_01_DF_01_91_33);
    checkOutput("yp_range_err", int'(frame_err), 1);
    check_frame("yp_range_hold", 639, 479, 400);

    $display("[TB] junk and sync-valued payload");
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    send_frame(64'hA5_00_A5_00_C8_01_00_6C);
    checkOutput("junk_frame_valid", int'(frame_valid), 1);
    check_frame("junk", 165, 200, 256);

    $display("[TB] out of range and padding");
    send_frame(64'hA5_07_FF_01_2C_00_FA_2F);
    checkOutput("x_range_err", int'(frame_err), 1);
    check_frame("x_range_hold", 165, 200, 256);
    send_frame(64'hA5_00_10_04_00_00_10_04);
    checkOutput("padding_err", int'(frame_err), 1);
    check_frame("padding_hold", 165, 200, 256);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h90);
    applyStimulus(8'h01);
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_frame("midrst", 312, 232, 200);
    checkOutput("midrst_link_up", int'(link_up), 0);
    send_frame(64'hA5_01_90_01_2C_00_FA_46);
    check_frame("after_rst", 400, 300, 250);

    $display("[TB] link timeout");
    waited = -1;
    for (int i = 1; i <= LT + 10; i++) begin
      idle(1);
      if (!link_up) begin
        waited = i;
        break;
      end
    end
    checkOutput("link_drop_wait", waited, LT);
    check_frame("link_hold", 400, 300, 250);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
